// File: rtl/tt_sweep_if.sv
// Truth-table sweeper bundle: start/s_in from the requester and function
// under test; vec drive and sweep results back from the sweeper.
//  master : drives start, s_in; observes vec and all results
//  slave  : the sweeper; consumes start, s_in; drives vec and results
interface tt_sweep_if #(
    parameter int N_IN = 3
);
    logic                 start;
    logic                 s_in;
    logic [N_IN-1:0]      vec;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [2**N_IN-1:0]   table_q;
    logic [N_IN:0]        mism_cnt;
    logic [N_IN-1:0]      first_bad;
    logic                 bad_valid;

    modport master (
        output start, s_in,
        input  vec, busy, done, pass, table_q,
        input  mism_cnt, first_bad, bad_valid
    );

    modport slave (
        input  start, s_in,
        output vec, busy, done, pass, table_q,
        output mism_cnt, first_bad, bad_valid
    );
endinterface

// File: rtl/tt_sweep_ctrl.sv
// Sequential truth-table sweeper: steps vec through 0..2**N_IN-1, samples
// s_in after a settle window, and scores the captured table against EXPECT.
//  clk, reset : rising-edge clock, async active-high reset
//  sw (slave) : start/s_in in; vec, busy, done, pass, table_q, mism_cnt,
//               first_bad, bad_valid out (all registered)
module tt_sweep_ctrl #(
    parameter int                      N_IN   = 3,
    parameter int                      SETTLE = 1,
    parameter logic [(1<<N_IN)-1:0]    EXPECT = 'h70
) (
    input  logic       clk,
    input  logic       reset,
    tt_sweep_if.slave  sw
);
    localparam int CW = $clog2(SETTLE + 1);
    localparam int MW = N_IN + 1;
    localparam logic [N_IN-1:0] LAST = '1;

    typedef enum logic [1:0] {
        IDLE,
        SETTLING,
        SAMPLE,
        DONE
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic          miss;
    logic [MW-1:0] mism_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        miss    = (sw.s_in != EXPECT[sw.vec]);
        mism_n  = sw.mism_cnt;
        unique case (state)
            IDLE: begin
                if (sw.start) state_n = SETTLING;
            end
            SETTLING: begin
                if (cnt == CW'(1)) state_n = SAMPLE;
            end
            SAMPLE: begin
                if (miss) mism_n = sw.mism_cnt + MW'(1);
                // DONE is taken before any increment, so vec never wraps
                if (sw.vec == LAST) state_n = DONE;
                else                state_n = SETTLING;
            end
            DONE: begin
                if (sw.start) state_n = SETTLING;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            sw.vec       <= '0;
            sw.busy      <= 1'b0;
            sw.done      <= 1'b0;
            sw.pass      <= 1'b0;
            sw.table_q   <= '0;
            sw.mism_cnt  <= '0;
            sw.first_bad <= '0;
            sw.bad_valid <= 1'b0;
        end else begin
            // status flags follow the next state so they stay registered
            sw.busy <= (state_n == SETTLING) || (state_n == SAMPLE);
            sw.done <= (state_n == DONE);
            sw.pass <= (state_n == DONE) && (mism_n == '0);
            unique case (state)
                IDLE, DONE: begin
                    if (sw.start) begin
                        cnt          <= CW'(SETTLE);
                        sw.vec       <= '0;
                        sw.table_q   <= '0;
                        sw.mism_cnt  <= '0;
                        sw.first_bad <= '0;
                        sw.bad_valid <= 1'b0;
                    end
                end
                SETTLING: begin
                    cnt <= cnt - CW'(1);
                end
                SAMPLE: begin
                    sw.table_q[sw.vec] <= sw.s_in;
                    sw.mism_cnt        <= mism_n;
                    if (miss && !sw.bad_valid) begin
                        sw.first_bad <= sw.vec;
                        sw.bad_valid <= 1'b1;
                    end
                    if (sw.vec != LAST) begin
                        sw.vec <= sw.vec + N_IN'(1);
                        cnt    <= CW'(SETTLE);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
